// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one aligned block request at a time, unpacks responses into IB packets.
// Optional FETCH_PERF_CNT_EN adds stall and discard counters.
package fetch_unit_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } FETCH_PACKET;
endpackage

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          PUSH_WIDTH = 4,
    parameter int          IB_SZ      = 32,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    input  logic [$clog2(IB_SZ):0]      ib_available_slots,
    output logic                        icache_req_valid,
    output logic [31:0]                 icache_req_addr,
    input  logic                        icache_req_ready,
    input  logic                        icache_resp_valid,
    input  logic [32*PUSH_WIDTH-1:0]    icache_resp_data,
    output FETCH_PACKET [PUSH_WIDTH-1:0] new_ib_entries
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_stall_cycles,
    output logic [31:0]                 perf_discards
`endif
);
    localparam int          SLOT_W    = $clog2(IB_SZ) + 1;
    localparam logic [31:0] BLK_BYTES = 32'(4 * PUSH_WIDTH);

    typedef enum logic [1:0] {ST_FETCH = 2'd0, ST_WAIT = 2'd1, ST_DRAIN = 2'd2} state_t;

    state_t      state_r, state_nx_s;
    logic [31:0] pc_r, pc_nx_s;
    logic [31:0] base_s, offset_s, redir_pc_s;
    logic        slots_ok_s, push_s;

    assign base_s     = pc_r & ~(BLK_BYTES - 32'd1);
    assign offset_s   = (pc_r >> 2) & 32'(PUSH_WIDTH - 1);
    assign redir_pc_s = redirect_pc & ~32'd3;
    assign slots_ok_s = (ib_available_slots >= SLOT_W'(PUSH_WIDTH));

    // Request generation and response unpacking into IB packets.
    always_comb begin
        icache_req_valid = 1'b0;
        icache_req_addr  = base_s;
        push_s           = 1'b0;
        new_ib_entries   = '0;
        if (!reset && (state_r == ST_FETCH) && slots_ok_s && !redirect_valid) begin
            icache_req_valid = 1'b1;
        end else begin
            icache_req_valid = 1'b0;
        end
        if (!reset && (state_r == ST_WAIT) && icache_resp_valid && !redirect_valid) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            // Words below the PC offset belong to the block but precede the target.
            if (push_s && (32'(i) >= offset_s)) begin
                new_ib_entries[i].valid = 1'b1;
                new_ib_entries[i].inst  = icache_resp_data[32*i +: 32];
                new_ib_entries[i].pc    = base_s + 32'(4 * i);
                new_ib_entries[i].npc   = base_s + 32'(4 * i) + 32'd4;
            end else begin
                new_ib_entries[i] = '0;
            end
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        case (state_r)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_nx_s = redir_pc_s;
                end else if (icache_req_valid && icache_req_ready) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_nx_s    = redir_pc_s;
                    state_nx_s = icache_resp_valid ? ST_FETCH : ST_DRAIN;
                end else if (icache_resp_valid) begin
                    pc_nx_s    = base_s + BLK_BYTES;
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    pc_nx_s = redir_pc_s;
                end else begin
                    pc_nx_s = pc_r;
                end
                // A stale response retires the drain even if another redirect lands with it.
                if (icache_resp_valid) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: begin
                state_nx_s = ST_FETCH;
                pc_nx_s    = pc_r;
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_FETCH;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_nx_s;
            pc_r    <= pc_nx_s;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_s, discard_s;
    assign stall_s   = (state_r == ST_FETCH) && !slots_ok_s;
    assign discard_s = icache_resp_valid &&
                       (((state_r == ST_WAIT) && redirect_valid) || (state_r == ST_DRAIN));

    // Performance counters, free-running with wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cycles <= 32'd0;
            perf_discards     <= 32'd0;
        end else begin
            perf_stall_cycles <= perf_stall_cycles + {31'd0, stall_s};
            perf_discards     <= perf_discards + {31'd0, discard_s};
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic against a transaction-level model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;
    localparam int PW = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic [5:0]           ib_available_slots;
    logic                 icache_req_valid;
    logic [31:0]          icache_req_addr;
    logic                 icache_req_ready;
    logic                 icache_resp_valid;
    logic [32*PW-1:0]     icache_resp_data;
    FETCH_PACKET [PW-1:0] new_ib_entries;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]          perf_stall_cycles, perf_discards;
`endif

    fetch_unit #(.PUSH_WIDTH(PW), .IB_SZ(32), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ib_available_slots(ib_available_slots),
        .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
        .icache_req_ready(icache_req_ready),
        .icache_resp_valid(icache_resp_valid), .icache_resp_data(icache_resp_data),
        .new_ib_entries(new_ib_entries)
`ifdef FETCH_PERF_CNT_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_discards(perf_discards)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: fetch PC, whether a request is in flight, and whether that in-flight response is stale.
    logic [31:0] m_pc = 32'h0;
    bit          m_out = 1'b0;
    bit          m_drop = 1'b0;
    int          m_stall = 0;
    int          m_disc = 0;
    // Cache model: cycles until the pending response (1 = this cycle), 0 = none pending.
    int          cdly = 0;
    int          next_delay = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pkt(input FETCH_PACKET [PW-1:0] obs, input FETCH_PACKET [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL entries observed=%h expected=%h", obs, exp);
        end
    endtask

    task automatic cyc(input bit rst, input int slots, input bit rdy, input bit rv, input logic [31:0] rpc);
        bit                   exp_v, resp, push, accept;
        logic [31:0]          base, off;
        FETCH_PACKET [PW-1:0] exp_e;
        reset              = rst;
        ib_available_slots = 6'(slots);
        icache_req_ready   = rdy;
        redirect_valid     = rv;
        redirect_pc        = rpc;
        resp               = (cdly == 1);
        icache_resp_valid  = resp;
        icache_resp_data   = {$urandom, $urandom, $urandom, $urandom};

        base   = m_pc & ~32'hF;
        off    = (m_pc >> 2) % 32'(PW);
        exp_v  = !rst && !m_out && (slots >= PW) && !rv;
        push   = !rst && resp && m_out && !m_drop && !rv;
        exp_e  = '0;
        for (int i = 0; i < PW; i++) begin
            if (push && (32'(i) >= off)) begin
                exp_e[i].valid = 1'b1;
                exp_e[i].inst  = icache_resp_data[32*i +: 32];
                exp_e[i].pc    = base + 32'(4*i);
                exp_e[i].npc   = base + 32'(4*i) + 32'd4;
            end
        end

        #4;
        chk("req_valid", {31'd0, icache_req_valid}, {31'd0, exp_v});
        if (exp_v) chk("req_addr", icache_req_addr, base);
        chk_pkt(new_ib_entries, exp_e);

        @(posedge clock);
        accept = exp_v && rdy;
        if (!rst && !m_out && (slots < PW)) m_stall++;
        if (rst) begin
            m_pc = 32'h0; m_out = 1'b0; m_drop = 1'b0; m_stall = 0; m_disc = 0;
        end else if (rv) begin
            m_pc = rpc & ~32'd3;
            if (m_out && resp) begin
                m_out = 1'b0; m_drop = 1'b0; m_disc++;
            end else if (m_out) begin
                m_drop = 1'b1;
            end
        end else if (m_out && resp) begin
            if (!m_drop) m_pc = base + 32'd16;
            else m_disc++;
            m_out = 1'b0; m_drop = 1'b0;
        end else if (accept) begin
            m_out = 1'b1;
        end
        if (resp) cdly = 0;
        else if (cdly > 1) cdly--;
        if (accept) cdly = next_delay;
        #1;
    endtask

    initial begin
        // Reset, then first block from 0
        cyc(1'b1, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        // Redirect in FETCH to a mid-block PC
        cyc(1'b0, 32, 1'b1, 1'b1, 32'h108);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        // Slot throttle
        repeat (3) cyc(1'b0, 3, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 4, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 4, 1'b1, 1'b0, 32'h0);
        // Redirect in WAIT, response one cycle later
        next_delay = 2;
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        next_delay = 1;
        cyc(1'b0, 32, 1'b1, 1'b1, 32'h40);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        // Redirect coincident with response
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b1, 32'h80);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        // Back-pressure, then wrap at the top of the address space
        repeat (3) cyc(1'b0, 32, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b1, 32'hFFFF_FFF3);
        repeat (3) cyc(1'b0, 32, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        // Reset mid-WAIT with a late response afterwards
        next_delay = 3;
        cyc(1'b0, 32, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 2, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 2, 1'b1, 1'b0, 32'h0);
        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            next_delay = int'($urandom_range(1, 3));
            cyc(($urandom % 300) == 0, int'($urandom_range(0, 32)), ($urandom % 4) != 0,
                ($urandom % 10) == 0, $urandom);
        end
`ifdef FETCH_PERF_CNT_EN
        #4;
        chk("perf_stall", perf_stall_cycles, 32'(m_stall));
        chk("perf_disc", perf_discards, 32'(m_disc));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
